data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Handshaked data-memory responder for the RISC-V core's load/store path.
//  Accepts one request at a time: address, F3 size code and write data.
//  Waits a programmable latency, then performs the byte/half/word access with
//  RV32I lane steering and load sign-extension.
//  Holds the response until the core takes it. Serves as the multi-cycle
//  replacement for the single-cycle data memory.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; power of two; index = addr[log2(DEPTH_WORDS)+1:2]
//  LATENCY      2     cycles from request accept to rsp_valid; legal range 1..15
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept; high only in IDLE
//  req_we     in   1   1=store, 0=load
//  req_f3     in   3   instruction F3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-aligned (rs2 value)
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   core accepts response
//  rsp_rdata  out  32  load result, extended; 0 for stores
//  rsp_err    out  1   access error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    Memory array contents are NOT cleared.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_valid at an edge, capture we/f3/addr/wdata,
//      load cnt=LATENCY-1 and go to WAIT.
//    WAIT: req_ready=0. Decrement cnt. At the edge with cnt==0, execute the access
//      (store commits, or load reads) and go to RESP.
//    RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until the rsp_ready
//      edge, then return to IDLE. rsp_valid drops the cycle after the handshake.
//  - Timing: if accept happens at edge k, rsp_valid is first visible after edge k+LATENCY.
//    Minimum spacing between requests is LATENCY+2 cycles.
//  - Loads: B/BU select byte addr[1:0]; H/HU select half addr[1].
//    B and H sign-extend bit 7 / bit 15; BU and HU zero-extend. W returns the whole word.
//    Load f3 011, 110 and 111 are treated as W.
//  - Stores: B writes wdata[7:0] into lane addr[1:0]; H writes wdata[15:0] into half addr[1].
//    f3[1:0]==10 or 11 writes the full word. Untouched lanes are preserved.
//    f3[2] is ignored for stores.
//  - Address bits above the index wrap (aliasing); no range error.
//  - Reset during WAIT abandons the request and the store is not committed.
//    Reset during RESP drops the response.
//  - req_valid asserted outside IDLE is ignored and not queued.
//    The core must hold the request until req_ready.
// CONFIGURATION
//  Macro DMEM_MISALIGN_TRAP_EN:
//   defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
//     The access goes through the full latency but no array write occurs;
//     rsp_err=1 and rsp_rdata=0.
//   undefined: low address bits below the access size are ignored (access is
//     force-aligned) and rsp_err is tied 0.
// STRUCTURE
//  - Package riscv_mem_pkg: F3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU),
//    FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP) and the 32-bit word width.
//  - Sub-module mem_lane_align (combinational): store byte-enable and data steering,
//    plus load extraction and extension. Shared later with any cache datapath.
//  - Top level holds the FSM, latency counter, request capture registers and the
//    reg array.
// TESTING
//  1 Reset: rst=0 mid-WAIT of a SW to 0x10 -> outputs 0; a later LW 0x10 returns the
//    pre-store value.
//  2 SW 0x8 data 0xDEADBEEF, then LW 0x8 -> rsp_rdata=0xDEADBEEF;
//    rsp_valid rises exactly LATENCY edges after accept.
//  3 SB 0x9 data 0x80 over 0x11223344, then LB 0x9 -> 0xFFFFFF80,
//    LBU 0x9 -> 0x00000080, LW 0x8 -> 0x11228044.
//  4 SH 0xA data 0x8001, then LH 0xA -> 0xFFFF8001, LHU 0xA -> 0x00008001.
//  5 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable,
//    req_ready=0, and a second req_valid is ignored.
//  6 LH 0x3: with macro -> rsp_err=1, rdata=0, no write;
//    without macro -> reads half at 0x2, rsp_err=0.
//    Also LW 0x1008 with DEPTH_WORDS=1024 aliases to 0x8.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32I data-memory path: F3 size codes,
// responder FSM encoding and the data word width.
package riscv_mem_pkg;

    localparam int WORD_W = 32;

    // Load/store F3 size codes as they appear in the instruction.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Responder FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// RV32I lane steering: store byte enables / replicated store data, and
// load byte/half extraction with sign or zero extension. Purely
// combinational so it can be reused by a cache datapath.
// Access size comes from f3[1:0] (00 byte, 01 half, 1x word); f3[2]
// selects zero-extension for loads and is ignored for stores.
// The word path ignores the low address bits; the half path ignores
// addr_lo[0]. Misalignment is only flagged, never acted on, here.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [2:0]        f3,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rword,
    output logic [3:0]        be,
    output logic [WORD_W-1:0] wword,
    output logic [WORD_W-1:0] rdata,
    output logic              misalign
);

    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    // Select the addressed byte and half of the stored word.
    always_comb begin
        lane_byte_s = 8'h00;
        case (addr_lo)
            2'b00:   lane_byte_s = rword[7:0];
            2'b01:   lane_byte_s = rword[15:8];
            2'b10:   lane_byte_s = rword[23:16];
            2'b11:   lane_byte_s = rword[31:24];
            default: lane_byte_s = 8'h00;
        endcase
        lane_half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    // Size decode: enables, steered store data, extended load data.
    always_comb begin
        be       = 4'b0000;
        wword    = 32'h0000_0000;
        rdata    = 32'h0000_0000;
        misalign = 1'b0;
        case (f3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                rdata = f3[2] ? {24'h00_0000, lane_byte_s}
                              : {{24{lane_byte_s[7]}}, lane_byte_s};
            end
            2'b01: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = f3[2] ? {16'h0000, lane_half_s}
                                 : {{16{lane_half_s[15]}}, lane_half_s};
                misalign = addr_lo[0];
            end
            default: begin
                be       = 4'b1111;
                wword    = wdata;
                rdata    = rword;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle data memory for the core's load/store path.
// One request at a time: IDLE accepts, WAIT counts down the latency,
// the access executes on the last WAIT edge, RESP holds the result
// until the core takes it.
// Build option: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses report rsp_err and never write the array; when
// undefined they are force-aligned and rsp_err stays 0.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  idx_s;
    logic [WORD_W-1:0] rword_s;
    logic [3:0]        be_s;
    logic [WORD_W-1:0] wword_s;
    logic [WORD_W-1:0] load_s;
    logic              misalign_s;
    logic              trap_s;
    logic              exec_s;
    logic              mem_wr_s;
    logic              unused_addr_s;

    // Address bits above the index alias onto the same word.
    assign unused_addr_s = ^req_addr[31:IDX_W+2];
    assign idx_s         = addr_q[IDX_W+1:2];
    assign rword_s       = mem[idx_s];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap_s = misalign_s;
`else
    assign trap_s = 1'b0;
`endif

    mem_lane_align u_align (
        .f3       (f3_q),
        .addr_lo  (addr_q[1:0]),
        .wdata    (wdata_q),
        .rword    (rword_s),
        .be       (be_s),
        .wword    (wword_s),
        .rdata    (load_s),
        .misalign (misalign_s)
    );

    // Next-state logic: request capture, latency countdown, response hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        exec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_f3;
                    addr_d  = req_addr[IDX_W+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    exec_s  = 1'b1;
                    rdata_d = (we_q || trap_s) ? 32'h0000_0000 : load_s;
                    err_d   = trap_s;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_wr_s = exec_s && we_q && !trap_s;

    // Control and response registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus a
// randomized run against a byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int LAT       = 2;
    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [MEM_BYTES];

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_f3    (req_f3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference: byte-addressed memory, size from f3[1:0], wrap at MEM_BYTES.
    task automatic ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int nb;
        int a;
        logic [31:0] v;
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        a  = int'(addr % MEM_BYTES);
        er = 1'b0;
        rd = 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % nb != 0) er = 1'b1;
`else
        a = a - (a % nb);
`endif
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + i];
                if (nb == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
                if (nb == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
                rd = v;
            end
        end
    endtask

    // Drive one request, wait for the response, complete the handshake.
    // lat = edges from accept to rsp_valid (-1 on timeout); vafter = rsp_valid after handshake.
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output logic vafter);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) lat = -1;
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        vafter = rsp_valid;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        logic er, eer, va;
        int lat;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b rdata=%h err=%b ready=%b, want 0/0/0/1",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        @(negedge clk); rst = 1'b1;
        ref_exec(1'b1, 3'b010, 32'h10, 32'hA5A5_0001, exp, eer);
        xact(1'b1, 3'b010, 32'h10, 32'hA5A5_0001, rd, er, lat, va);
        // Start a store and reset it in the middle of WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h1234_5678;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #2; rst = 1'b0; #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_wait: valid=%b rdata=%h err=%b, want 0/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk); rst = 1'b1;
        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL reset_no_commit: got %h want %h", rd, 32'hA5A5_0001);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd, exp;
        logic er, eer, va;
        int lat;
        ref_exec(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, exp, eer);
        xact(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, rd, er, lat, va);
        checks++;
        if (lat !== LAT || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_latency: lat=%0d rdata=%h, want %0d / 0", lat, rd, LAT);
        end
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat !== LAT) begin
            errors++;
            $display("FAIL lw_word: rdata=%h lat=%0d, want DEADBEEF / %0d", rd, lat, LAT);
        end
        checks++;
        if (va !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: rsp_valid=%b after handshake, want 0", va);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd, exp;
        logic er, eer, va;
        int lat;
        ref_exec(1'b1, 3'b010, 32'h8, 32'h1122_3344, exp, eer);
        xact(1'b1, 3'b010, 32'h8, 32'h1122_3344, rd, er, lat, va);
        ref_exec(1'b1, 3'b000, 32'h9, 32'h0000_0080, exp, eer);
        xact(1'b1, 3'b000, 32'h9, 32'h0000_0080, rd, er, lat, va);
        xact(1'b0, 3'b000, 32'h9, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb: got %h want FFFFFF80", rd); end
        xact(1'b0, 3'b100, 32'h9, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: got %h want 00000080", rd); end
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'h1122_8044) begin errors++; $display("FAIL sb_merge: got %h want 11228044", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd, exp;
        logic er, eer, va;
        int lat;
        ref_exec(1'b1, 3'b001, 32'hA, 32'h0000_8001, exp, eer);
        xact(1'b1, 3'b001, 32'hA, 32'h0000_8001, rd, er, lat, va);
        xact(1'b0, 3'b001, 32'hA, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: got %h want FFFF8001", rd); end
        xact(1'b0, 3'b101, 32'hA, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu: got %h want 00008001", rd); end
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== 32'h8001_8044) begin errors++; $display("FAIL sh_merge: got %h want 80018044", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, exp, held;
        logic er, eer, va;
        int lat, n;
        ref_exec(1'b0, 3'b010, 32'h8, 32'h0, exp, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
        rsp_ready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        held = rsp_rdata;
        checks++;
        if (rsp_valid !== 1'b1 || held !== exp) begin
            errors++;
            $display("FAIL bp_first: valid=%b rdata=%h, want 1 / %h", rsp_valid, held, exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b, want 1/%h/0",
                         i, rsp_valid, rsp_rdata, req_ready, held);
            end
        end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: valid=%b want 0", rsp_valid); end
        xact(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL bp_ignored_req: got %h want %h", rd, exp); end
    endtask

    task automatic test_misalign_alias();
        logic [31:0] rd, exp;
        logic er, eer, va;
        int lat;
        ref_exec(1'b1, 3'b010, 32'h0, 32'hCAFE_1234, exp, eer);
        xact(1'b1, 3'b010, 32'h0, 32'hCAFE_1234, rd, er, lat, va);
        ref_exec(1'b0, 3'b001, 32'h3, 32'h0, exp, eer);
        xact(1'b0, 3'b001, 32'h3, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== exp || er !== eer || lat !== LAT) begin
            errors++;
            $display("FAIL lh_misalign: rdata=%h err=%b lat=%0d, want %h/%b/%0d", rd, er, lat, exp, eer, LAT);
        end
        ref_exec(1'b1, 3'b010, 32'h1, 32'hFFFF_FFFF, exp, eer);
        xact(1'b1, 3'b010, 32'h1, 32'hFFFF_FFFF, rd, er, lat, va);
        checks++;
        if (rd !== 32'h0 || er !== eer) begin
            errors++;
            $display("FAIL sw_misalign: rdata=%h err=%b, want 0/%b", rd, er, eer);
        end
        ref_exec(1'b0, 3'b010, 32'h0, 32'h0, exp, eer);
        xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== exp) begin errors++; $display("FAIL sw_misalign_effect: got %h want %h", rd, exp); end
        ref_exec(1'b0, 3'b010, 32'h1008, 32'h0, exp, eer);
        xact(1'b0, 3'b010, 32'h1008, 32'h0, rd, er, lat, va);
        checks++;
        if (rd !== exp || rd !== 32'h8001_8044) begin
            errors++;
            $display("FAIL alias: got %h want %h", rd, exp);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, addr, wd;
        logic er, eer, va, we;
        logic [2:0] f3;
        int lat;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            ref_exec(1'b1, 3'b010, 32'(w * 4), wd, exp, eer);
            xact(1'b1, 3'b010, 32'(w * 4), wd, rd, er, lat, va);
        end
        for (int t = 0; t < 80; t++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom << 12) | 32'($urandom_range(0, 63));
            wd   = $urandom;
            ref_exec(we, f3, addr, wd, exp, eer);
            xact(we, f3, addr, wd, rd, er, lat, va);
            checks++;
            if (rd !== exp || er !== eer || lat !== LAT || va !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d we=%b f3=%b addr=%h: rdata=%h err=%b lat=%0d, want %h/%b/%0d",
                         t, we, f3, addr, rd, er, lat, exp, eer, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_backpressure();
        test_misalign_alias();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
